// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM state encoding,
// idle/reset constants and the column priority encoder.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2
  } state_t;

  localparam logic [3:0] ROW_RESET = 4'b1110;
  localparam logic [3:0] COLS_IDLE = 4'hF;

  // Index of the lowest low (active) bit; several low bits resolve to the
  // lowest index. An all-idle pattern maps to 0 and is never latched.
  function automatic logic [1:0] col_to_idx(input logic [3:0] cols);
    if (!cols[0])      return 2'd0;
    else if (!cols[1]) return 2'd1;
    else if (!cols[2]) return 2'd2;
    else if (!cols[3]) return 2'd3;
    else               return 2'd0;
  endfunction

endpackage

// File: rtl/keypad_4x4_scanner_if.sv
// Keypad-side signal bundle. The slave modport is the scanner; the master
// modport is whatever drives the column returns and consumes key codes.
// Handshake: key_valid is a one-cycle strobe qualifying key_value; there is
// no ready, the consumer must take the code in the strobe cycle.
interface keypad_4x4_scanner_if;
  import keypad_pkg::*;

  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] key_value;
  logic       key_valid;
  logic       key_held;
  state_t     dbg_state;

  modport slave (
    input  col_in,
    output row_out, key_value, key_valid, key_held, dbg_state
  );

  modport master (
    output col_in,
    input  row_out, key_value, key_valid, key_held, dbg_state
  );

endinterface

// File: rtl/keypad_sync2.sv
// Two-flop synchronizer for the asynchronous column returns. Reset loads the
// idle (all released) pattern so no phantom press is seen after reset.
module keypad_sync2
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] i_async,
  output logic [3:0] o_sync
);

  logic [3:0] r_meta;
  logic [3:0] r_sync;

  // Two-stage capture of the column inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= COLS_IDLE;
      r_sync <= COLS_IDLE;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/keypad_4x4_scanner.sv
// 4x4 matrix keypad scanner: drives one row low at a time, samples the
// synchronized columns once per row dwell, debounces press and release and
// emits {row,col} key codes with a one-cycle valid strobe.
// Optional feature: define KEYPAD_REPEAT_EN for auto-repeat of a held key.
module keypad_4x4_scanner
  import keypad_pkg::*;
#(
  parameter int ROW_DWELL    = 100_000,
  parameter int DEB_COUNT    = 20
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  keypad_4x4_scanner_if.slave   bus
);

  localparam int DW_W = (ROW_DWELL > 1) ? $clog2(ROW_DWELL) : 1;
  localparam int DB_W = $clog2(DEB_COUNT + 1);
`ifdef KEYPAD_REPEAT_EN
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RP_W   = $clog2(RP_MAX + 1);
`endif

  logic [3:0]      w_col_s;
  logic [DW_W-1:0] r_dwell;
  logic            w_sample;
  logic [3:0]      w_rot;

  state_t          r_state,     w_state;
  logic [3:0]      r_row,       w_row;
  logic [3:0]      r_code,      w_code;
  logic [3:0]      r_pat,       w_pat;
  logic [DB_W-1:0] r_deb_cnt,   w_deb_cnt;
  logic [DB_W-1:0] r_rel_cnt,   w_rel_cnt;
  logic [3:0]      r_key_value, w_key_value;
  logic            r_key_valid, w_key_valid;
  logic            r_key_held,  w_key_held;
`ifdef KEYPAD_REPEAT_EN
  logic [RP_W-1:0] r_rep_cnt,   w_rep_cnt;
  logic            r_rep_arm,   w_rep_arm;
`endif

  keypad_sync2 u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (bus.col_in),
    .o_sync  (w_col_s)
  );

  // Free-running row dwell counter; the terminal count is the sample point.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_dwell <= '0;
    else if (w_sample) r_dwell <= '0;
    else               r_dwell <= r_dwell + DW_W'(1);
  end

  assign w_sample = (32'(r_dwell) == ROW_DWELL - 1);
  assign w_rot    = {r_row[2:0], r_row[3]};

  // FSM and datapath state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= SCAN;
      r_row       <= ROW_RESET;
      r_code      <= '0;
      r_pat       <= COLS_IDLE;
      r_deb_cnt   <= '0;
      r_rel_cnt   <= '0;
      r_key_value <= '0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rep_cnt   <= '0;
      r_rep_arm   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state;
      r_row       <= w_row;
      r_code      <= w_code;
      r_pat       <= w_pat;
      r_deb_cnt   <= w_deb_cnt;
      r_rel_cnt   <= w_rel_cnt;
      r_key_value <= w_key_value;
      r_key_valid <= w_key_valid;
      r_key_held  <= w_key_held;
`ifdef KEYPAD_REPEAT_EN
      r_rep_cnt   <= w_rep_cnt;
      r_rep_arm   <= w_rep_arm;
`endif
    end
  end

  // Next-state and output decisions; everything only moves on a sample.
  always_comb begin
    w_state     = r_state;
    w_row       = r_row;
    w_code      = r_code;
    w_pat       = r_pat;
    w_deb_cnt   = r_deb_cnt;
    w_rel_cnt   = r_rel_cnt;
    w_key_value = r_key_value;
    w_key_valid = 1'b0;
    w_key_held  = r_key_held;
`ifdef KEYPAD_REPEAT_EN
    w_rep_cnt   = r_rep_cnt;
    w_rep_arm   = r_rep_arm;
`endif
    if (w_sample) begin
      unique case (r_state)
        SCAN: begin
          if (w_col_s == COLS_IDLE) begin
            w_row = w_rot;
          end else begin
            // The detection sample is the first of the debounce run.
            w_code    = {col_to_idx(r_row), col_to_idx(w_col_s)};
            w_pat     = w_col_s;
            w_deb_cnt = DB_W'(1);
            w_state   = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (w_col_s == r_pat) begin
            if (32'(r_deb_cnt) + 1 == DEB_COUNT) begin
              w_key_value = r_code;
              w_key_valid = 1'b1;
              w_key_held  = 1'b1;
              w_rel_cnt   = '0;
`ifdef KEYPAD_REPEAT_EN
              w_rep_cnt   = '0;
              w_rep_arm   = 1'b0;
`endif
              w_state     = PRESSED;
            end else begin
              w_deb_cnt = r_deb_cnt + DB_W'(1);
            end
          end else begin
            // Bounce or a different key: give up and move on.
            w_state = SCAN;
            w_row   = w_rot;
          end
        end
        PRESSED: begin
          if (w_col_s == COLS_IDLE) begin
`ifdef KEYPAD_REPEAT_EN
            w_rep_cnt = '0;
            w_rep_arm = 1'b0;
`endif
            if (32'(r_rel_cnt) + 1 == DEB_COUNT) begin
              w_key_held = 1'b0;
              w_rel_cnt  = '0;
              w_state    = SCAN;
              w_row      = w_rot;
            end else begin
              w_rel_cnt = r_rel_cnt + DB_W'(1);
            end
          end else begin
            // Any low bit (including a second key) counts as still held.
            w_rel_cnt = '0;
`ifdef KEYPAD_REPEAT_EN
            // First repeat after REPEAT_DELAY samples, then every REPEAT_RATE.
            if (32'(r_rep_cnt) + 1 == (r_rep_arm ? REPEAT_RATE : REPEAT_DELAY)) begin
              w_key_valid = 1'b1;
              w_rep_cnt   = '0;
              w_rep_arm   = 1'b1;
            end else begin
              w_rep_cnt = r_rep_cnt + RP_W'(1);
            end
`endif
          end
        end
        default: w_state = SCAN;
      endcase
    end
  end

  assign bus.row_out   = r_row;
  assign bus.key_value = r_key_value;
  assign bus.key_valid = r_key_valid;
  assign bus.key_held  = r_key_held;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_keypad_4x4_scanner.sv
// Bench for keypad_4x4_scanner: a physical keypad matrix model closes the loop
// from row_out to col_in; a sample-level behavioural model predicts outputs.
module tb_keypad_4x4_scanner;
  import keypad_pkg::*;

  localparam int ROW_DWELL    = 4;
  localparam int DEB_COUNT    = 3;
`ifdef KEYPAD_REPEAT_EN
  localparam int REPEAT_DELAY = 5;
  localparam int REPEAT_RATE  = 2;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  keypad_4x4_scanner_if kif();

  // keys[r][c] = 1 means the key at row r, column c is pressed.
  logic [3:0] keys [4];

  // Passive matrix: a pressed key pulls its column low when its row is driven.
  always_comb begin
    kif.col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!kif.row_out[r]) kif.col_in = kif.col_in & ~keys[r];
  end

  keypad_4x4_scanner #(
    .ROW_DWELL    (ROW_DWELL),
    .DEB_COUNT    (DEB_COUNT)
`ifdef KEYPAD_REPEAT_EN
    ,
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
`endif
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (kif)
  );

  // ---------------- scoreboard counters ----------------
  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model (one step per clock) ----------------
  int         m_ph, m_row, m_mode, m_run, m_rel;
`ifdef KEYPAD_REPEAT_EN
  int         m_hold;
`endif
  logic [3:0] m_c1, m_c2, m_pat, m_code;
  logic [3:0] exp_value;
  logic       exp_valid, exp_held;

  function automatic int lowest_low(input logic [3:0] v);
    for (int c = 0; c < 4; c++) if (!v[c]) return c;
    return 0;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_row = 0; m_mode = 0; m_run = 0; m_rel = 0;
`ifdef KEYPAD_REPEAT_EN
    m_hold = 0;
`endif
    m_c1 = 4'hF; m_c2 = 4'hF; m_pat = 4'hF; m_code = 4'h0;
    exp_value = 4'h0; exp_valid = 1'b0; exp_held = 1'b0;
  endtask

  // s is what the scanner sees this cycle: column lines two clocks ago.
  task automatic model_step();
    logic [3:0] s;
    s = m_c2;
    m_c2 = m_c1;
    m_c1 = ~keys[m_row];
    exp_valid = 1'b0;
    if (m_ph == ROW_DWELL - 1) begin
      m_ph = 0;
      case (m_mode)
        0: begin
          if (s == 4'hF) m_row = (m_row + 1) % 4;
          else begin
            m_pat  = s;
            m_code = 4'(m_row * 4 + lowest_low(s));
            m_run  = 1;
            m_mode = 1;
          end
        end
        1: begin
          if (s == m_pat) begin
            m_run++;
            if (m_run == DEB_COUNT) begin
              exp_value = m_code; exp_valid = 1'b1; exp_held = 1'b1;
              m_mode = 2; m_rel = 0;
`ifdef KEYPAD_REPEAT_EN
              m_hold = 0;
`endif
            end
          end else begin
            m_mode = 0;
            m_row = (m_row + 1) % 4;
          end
        end
        default: begin
          if (s == 4'hF) begin
            m_rel++;
`ifdef KEYPAD_REPEAT_EN
            m_hold = 0;
`endif
            if (m_rel == DEB_COUNT) begin
              exp_held = 1'b0;
              m_mode = 0;
              m_row = (m_row + 1) % 4;
            end
          end else begin
            m_rel = 0;
`ifdef KEYPAD_REPEAT_EN
            m_hold++;
            if (m_hold == REPEAT_DELAY ||
                (m_hold > REPEAT_DELAY && (m_hold - REPEAT_DELAY) % REPEAT_RATE == 0))
              exp_valid = 1'b1;
`endif
          end
        end
      endcase
    end else begin
      m_ph++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    logic [3:0] er;
    state_t es;
    @(posedge clk);
    model_step();
    @(negedge clk);
    er = 4'hF;
    er[m_row] = 1'b0;
    es = (m_mode == 0) ? SCAN : (m_mode == 1) ? DEBOUNCE : PRESSED;
    check("row_out",   32'(kif.row_out),   32'(er));
    check("key_valid", 32'(kif.key_valid), 32'(exp_valid));
    check("key_value", 32'(kif.key_value), 32'(exp_value));
    check("key_held",  32'(kif.key_held),  32'(exp_held));
    check("state",     32'(kif.dbg_state), 32'(es));
    if (kif.key_valid === 1'b1) pulses++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (kif.key_valid === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_released(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (kif.key_held === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic clear_keys();
    for (int r = 0; r < 4; r++) keys[r] = 4'h0;
  endtask

  // ---------------- stimulus tables ----------------
  typedef struct {
    int         after;
    logic [3:0] row;
  } row_vec_t;

  typedef struct {
    int         row;
    logic [3:0] cols;
    logic [3:0] exp_code;
    logic [3:0] exp_rowout;
  } press_vec_t;

  row_vec_t   row_tab [5];
  press_vec_t press_tab [5];

  initial begin
    bit ok;
    int base;
    int t;
    int rep_exp;

    row_tab[0] = '{3,  4'b1110};
    row_tab[1] = '{4,  4'b1101};
    row_tab[2] = '{8,  4'b1011};
    row_tab[3] = '{12, 4'b0111};
    row_tab[4] = '{16, 4'b1110};

    press_tab[0] = '{0, 4'b1001, 4'h1, 4'b1110};
    press_tab[1] = '{3, 4'b0111, 4'hF, 4'b0111};
    press_tab[2] = '{1, 4'b1110, 4'h4, 4'b1101};
    press_tab[3] = '{1, 4'b0011, 4'h6, 4'b1101};
    press_tab[4] = '{3, 4'b1011, 4'hE, 4'b0111};

    clear_keys();
    model_reset();

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_row_out",   32'(kif.row_out),   32'(4'b1110));
    check("rst_key_value", 32'(kif.key_value), 32'(4'h0));
    check("rst_key_valid", 32'(kif.key_valid), 32'(1'b0));
    check("rst_key_held",  32'(kif.key_held),  32'(1'b0));
    check("rst_state",     32'(kif.dbg_state), 32'(SCAN));
    reset_n = 1'b1;

    // 1. Idle scan rotation.
    pulses = 0;
    t = 0;
    for (int i = 0; i < 5; i++) begin
      while (t < row_tab[i].after) begin tick(); t++; end
      check("idle_row", 32'(kif.row_out), 32'(row_tab[i].row));
    end
    check("idle_no_pulse", 32'(pulses), 32'(0));

    // 2. Clean press row2/col1 held 20 samples.
    keys[2] = 4'b0010;
    wait_valid(200, ok);
    check("press9_seen",  32'(ok), 32'(1));
    check("press9_value", 32'(kif.key_value), 32'(4'h9));
    check("press9_held",  32'(kif.key_held), 32'(1));
    pulses = 0;
    ticks(20 * ROW_DWELL);
`ifdef KEYPAD_REPEAT_EN
    rep_exp = 8;
`else
    rep_exp = 0;
`endif
    check("press9_repeats", 32'(pulses), 32'(rep_exp));
    check("press9_frozen",  32'(kif.row_out), 32'(4'b1011));

    // 4. Release glitch of two samples, then full release.
    keys[2] = 4'b0000;
    ticks(2 * ROW_DWELL);
    keys[2] = 4'b0010;
    ticks(4 * ROW_DWELL);
    check("glitch_held", 32'(kif.key_held), 32'(1));
    keys[2] = 4'b0000;
    wait_released(40, ok);
    check("release_seen", 32'(ok), 32'(1));
    check("release_row",  32'(kif.row_out), 32'(4'b0111));

    // 3. Bounce: alternate every sample for 6 samples, then stable.
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      keys[2] = (k % 2 == 0) ? 4'b0010 : 4'b0000;
      ticks(ROW_DWELL);
    end
    check("bounce_no_pulse", 32'(pulses), 32'(0));
    keys[2] = 4'b0010;
    wait_valid(200, ok);
    check("bounce_accept", 32'(ok), 32'(1));
    ticks(2 * ROW_DWELL);
    check("bounce_one_pulse", 32'(pulses), 32'(1));
    keys[2] = 4'b0000;
    wait_released(40, ok);
    check("bounce_release", 32'(ok), 32'(1));

    // Table of presses including multi-column resolution (5: 1001 -> 1).
    for (int i = 0; i < 5; i++) begin
      keys[press_tab[i].row] = ~press_tab[i].cols;
      wait_valid(200, ok);
      check("tab_seen",  32'(ok), 32'(1));
      check("tab_value", 32'(kif.key_value), 32'(press_tab[i].exp_code));
      check("tab_held",  32'(kif.key_held), 32'(1));
      check("tab_row",   32'(kif.row_out), 32'(press_tab[i].exp_rowout));
      clear_keys();
      wait_released(40, ok);
      check("tab_release", 32'(ok), 32'(1));
      ticks($urandom_range(0, 7));
    end

    // 5. Reset asserted mid-DEBOUNCE.
    keys[0] = 4'b0001;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (m_mode == 1) begin ok = 1'b1; break; end
    end
    check("deb_reached", 32'(ok), 32'(1));
    #2 reset_n = 1'b0;
    #1;
    check("midrst_row",   32'(kif.row_out),   32'(4'b1110));
    check("midrst_value", 32'(kif.key_value), 32'(4'h0));
    check("midrst_valid", 32'(kif.key_valid), 32'(1'b0));
    check("midrst_held",  32'(kif.key_held),  32'(1'b0));
    check("midrst_state", 32'(kif.dbg_state), 32'(SCAN));
    clear_keys();
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    ticks(30);
    check("midrst_no_pulse", 32'(pulses), 32'(0));

    // 6. Key F held 12 samples after accept.
    keys[3] = 4'b1000;
    wait_valid(200, ok);
    check("keyF_seen",  32'(ok), 32'(1));
    check("keyF_value", 32'(kif.key_value), 32'(4'hF));
    pulses = 0;
    ticks(12 * ROW_DWELL);
`ifdef KEYPAD_REPEAT_EN
    rep_exp = 4;
`else
    rep_exp = 0;
`endif
    check("keyF_repeats", 32'(pulses), 32'(rep_exp));
    clear_keys();
    wait_released(40, ok);
    check("keyF_release", 32'(ok), 32'(1));

    // Randomized presses, checked every cycle against the model.
    for (int n = 0; n < 30; n++) begin
      base = $urandom_range(0, 3);
      keys[base] = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 3) == 0) keys[$urandom_range(0, 3)] = 4'($urandom_range(1, 15));
      ticks($urandom_range(1, 10) * ROW_DWELL + $urandom_range(0, 3));
      clear_keys();
      ticks($urandom_range(1, 10) * ROW_DWELL + $urandom_range(0, 3));
    end
    ticks(10 * ROW_DWELL);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
